// File: rtl/rsa_decrypt.sv
// rsa_decrypt: m = c^d mod n, constant-time LSB-first square-and-multiply on bit-serial modular multipliers.
// Latency: done_compute rises 1 + WIDTH*(WIDTH+1) edges after start is accepted (1 edge on operand error).
// Handshake: start_compute is a level request held until done_compute; new work is accepted only from IDLE.
module rsa_decrypt #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] n,
  input  logic             start_compute,
  output logic [WIDTH-1:0] m,
  output logic             done_compute,
  output logic             busy,
  output logic             err
);

  localparam int KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  // Two guard bits: 2*acc + operand stays below 3*nreg < 2^(WIDTH+2).
  localparam int AW = WIDTH + 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_MULT,
    ST_UPDATE,
    ST_END
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] nreg;
  logic [WIDTH-1:0] ereg;
  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] result;
  logic [AW-1:0]    acc_r;
  logic [AW-1:0]    acc_s;
  logic [KW-1:0]    it;
  logic [KW-1:0]    k;

  logic             bit_k;
  logic [AW-1:0]    r_sum;
  logic [AW-1:0]    s_sum;
  logic [AW-1:0]    r_next;
  logic [AW-1:0]    s_next;
  logic [WIDTH-1:0] res_upd;

  // Bring a value below 3*nn back into [0, nn) with at most two subtractions.
  function automatic logic [AW-1:0] red(input logic [AW-1:0] x, input logic [AW-1:0] nn);
    logic [AW-1:0] y;
    y = x;
    if (y >= nn) y = y - nn;
    if (y >= nn) y = y - nn;
    return y;
  endfunction

  // One interleaved step of both multipliers (result*base and base*base), sharing the multiplier bit base[k].
  always_comb begin
    bit_k   = base[k];
    r_sum   = (acc_r << 1) + (bit_k ? AW'(result) : '0);
    s_sum   = (acc_s << 1) + (bit_k ? AW'(base) : '0);
    r_next  = red(r_sum, AW'(nreg));
    s_next  = red(s_sum, AW'(nreg));
    res_upd = ereg[0] ? acc_r[WIDTH-1:0] : result;
  end

  // Control FSM and datapath registers; all outputs are registered here.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      nreg         <= '0;
      ereg         <= '0;
      base         <= '0;
      result       <= '0;
      acc_r        <= '0;
      acc_s        <= '0;
      it           <= '0;
      k            <= '0;
      m            <= '0;
      done_compute <= 1'b0;
      busy         <= 1'b0;
      err          <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_compute) begin
            nreg  <= n;
            ereg  <= d;
            base  <= c;
            busy  <= 1'b1;
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          m <= '0;
          if (nreg < WIDTH'(2) || base >= nreg) begin
            err          <= 1'b1;
            done_compute <= 1'b1;
            busy         <= 1'b0;
            state        <= ST_END;
          end else begin
            result <= WIDTH'(1);
            it     <= '0;
            k      <= KW'(WIDTH - 1);
            acc_r  <= '0;
            acc_s  <= '0;
            state  <= ST_MULT;
          end
        end
        ST_MULT: begin
          acc_r <= r_next;
          acc_s <= s_next;
          if (k == '0) state <= ST_UPDATE;
          else         k     <= k - 1'b1;
        end
        ST_UPDATE: begin
          result <= res_upd;
          base   <= acc_s[WIDTH-1:0];
          ereg   <= ereg >> 1;
          it     <= it + 1'b1;
          acc_r  <= '0;
          acc_s  <= '0;
          k      <= KW'(WIDTH - 1);
          if (it == KW'(WIDTH - 1)) begin
            m            <= res_upd;
            done_compute <= 1'b1;
            busy         <= 1'b0;
            state        <= ST_END;
          end else begin
            state <= ST_MULT;
          end
        end
        ST_END: begin
          if (!start_compute) begin
            done_compute <= 1'b0;
            err          <= 1'b0;
            state        <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_decrypt.sv
// Scoreboard bench for rsa_decrypt: expected {m, err, completion cycle} are queued at request time
// and a monitor pops one entry on every rising edge of done_compute.
module tb_rsa_decrypt;

  localparam int W   = 64;
  localparam int LAT = 1 + W * (W + 1);

  typedef struct {
    logic [W-1:0] m;
    logic         err;
    int           cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] c = '0;
  logic [W-1:0] d = '0;
  logic [W-1:0] n = '0;
  logic         start_compute = 1'b0;
  logic [W-1:0] m;
  logic         done_compute;
  logic         busy;
  logic         err;

  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  logic done_prev = 1'b0;
  exp_t sbq[$];

  rsa_decrypt #(.WIDTH(W)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .c             (c),
    .d             (d),
    .n             (n),
    .start_compute (start_compute),
    .m             (m),
    .done_compute  (done_compute),
    .busy          (busy),
    .err           (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Reference: textbook modular exponentiation using wide integer arithmetic.
  function automatic exp_t model(input logic [W-1:0] cc, input logic [W-1:0] dd, input logic [W-1:0] nn);
    exp_t e;
    logic [2*W-1:0] r, b, nw;
    e.cyc = 0;
    if (nn < 2 || cc >= nn) begin
      e.m   = '0;
      e.err = 1'b1;
    end else begin
      nw = {{W{1'b0}}, nn};
      r  = 1;
      b  = {{W{1'b0}}, cc};
      for (int i = 0; i < W; i++) begin
        if (dd[i]) r = (r * b) % nw;
        b = (b * b) % nw;
      end
      e.m   = r[W-1:0];
      e.err = 1'b0;
    end
    return e;
  endfunction

  // Monitor: compare every completed result against the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset_n && done_compute && !done_prev) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done with m=%0d, expected no completion", m);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("result_m", m, e.m);
        chk("result_err", W'(err), W'(e.err));
        chk("latency_cycle", W'(cyc), W'(e.cyc));
      end
    end
    done_prev <= done_compute;
  end

  // Issue one request; drop_at>0 releases start that many cycles in, otherwise it is held through END.
  task automatic run(input logic [W-1:0] cc, input logic [W-1:0] dd, input logic [W-1:0] nn,
                     input int drop_at);
    exp_t e;
    int   t;
    @(negedge clk);
    c = cc; d = dd; n = nn; start_compute = 1'b1;
    e = model(cc, dd, nn);
    e.cyc = cyc + 1 + ((nn < 2 || cc >= nn) ? 1 : LAT);
    sbq.push_back(e);
    t = 0;
    while (!done_compute && t < LAT + 50) begin
      @(negedge clk);
      t++;
      if (t == 3 && !e.err) chk("busy_running", W'(busy), W'(1));
      if (t == drop_at) start_compute = 1'b0;
    end
    if (!done_compute) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got done=0 after %0d cycles, expected done=1", t);
      start_compute = 1'b0;
      return;
    end
    if (drop_at > 0) begin
      @(negedge clk);
      chk("one_cycle_done", W'(done_compute), W'(0));
    end else begin
      @(negedge clk);
      chk("done_held", W'(done_compute), W'(1));
      start_compute = 1'b0;
      @(negedge clk);
      chk("done_cleared", W'(done_compute), W'(0));
      chk("err_cleared", W'(err), W'(0));
      chk("m_holds", m, e.m);
    end
  endtask

  initial begin
    logic [W-1:0] rn, rc, rd;
    repeat (3) @(negedge clk);
    chk("reset_m", m, '0);
    chk("reset_done", W'(done_compute), W'(0));
    chk("reset_busy", W'(busy), W'(0));
    chk("reset_err", W'(err), W'(0));
    reset_n = 1'b1;

    run(64'd2790, 64'd2753, 64'd3233, 0);   // 65
    run(64'd65,   64'd17,   64'd3233, 0);   // 2790
    run(64'd123,  64'd17,   64'd3233, 0);   // 855
    run(64'd1000, 64'd0,    64'd3233, 0);   // 1
    run(64'd0,    64'd5,    64'd3233, 0);   // 0
    run(64'd3232, 64'd1,    64'd3233, 0);   // 3232
    run(64'd0,    64'd5,    64'd1,    0);   // err: n<2
    run(64'd3233, 64'd5,    64'd3233, 0);   // err: c>=n
    run(64'hFFFF_FFFF_FFFF_FFC4, 64'd2, 64'hFFFF_FFFF_FFFF_FFC5, 0);  // (n-1)^2 mod n = 1

    // Abort mid-operation with reset, then restart.
    @(negedge clk);
    c = 64'd2790; d = 64'd2753; n = 64'd3233; start_compute = 1'b1;
    repeat (2000) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk("abort_m", m, '0);
    chk("abort_done", W'(done_compute), W'(0));
    chk("abort_busy", W'(busy), W'(0));
    chk("abort_err", W'(err), W'(0));
    reset_n = 1'b1;
    start_compute = 1'b0;
    run(64'd2790, 64'd2753, 64'd3233, 0);

    // Early release of start is ignored; done pulses for one cycle.
    run(64'd2790, 64'd2753, 64'd3233, 100);

    for (int i = 0; i < 3; i++) begin
      rn = {$urandom(), $urandom()} | 64'h8000_0000_0000_0001;
      rc = {$urandom(), $urandom()} % rn;
      rd = {$urandom(), $urandom()};
      run(rc, rd, rn, 0);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", W'(sbq.size()), W'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
